dff_delay_bank: RTL and testbench

Parametrised successor to the single D flip-flop with reset: a bank of WIDTH independent channels, each a DEPTH-stage register chain with enable, synchronous clear, toggle mode, fill tracking and per-channel edge detection. It serves as the common registered-delay / retiming element between stimulus logic and checkers in the test-bench designs. With WIDTH=1, DEPTH=1, mode D and en tied high it behaves exactly like a plain DFF with q/qb.

---
 rtl/dff_delay_bank_pkg.sv | 29 ++
 rtl/dff_delay_bank_stage.sv | 44 ++++
 rtl/dff_delay_bank.sv | 128 ++++++++++++
 tb/tb_dff_delay_bank.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dff_delay_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dff_delay_bank_pkg
//  Description : Shared definitions for the dff_delay_bank registered-delay
//                element: mode encodings and a ceiling-log2 helper used to
//                size the fill counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package dff_delay_bank_pkg;

   // Mode encodings; 2'b11 is reserved and behaves like MODE_HOLD.
   localparam logic [1:0] MODE_D    = 2'b00;
   localparam logic [1:0] MODE_T    = 2'b01;
   localparam logic [1:0] MODE_HOLD = 2'b10;

   // Smallest r such that (1 << r) >= value.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage : dff_delay_bank_pkg
`default_nettype wire

// File: rtl/dff_delay_bank_stage.sv
`default_nettype none
// ============================================================================
//  Module      : dff_delay_bank_stage
//  Description : One WIDTH-bit stage of the delay bank. Asynchronous reset
//                and synchronous clear both load RST_VAL; clear has priority
//                over the load enable.
//  Ports       : clk   - rising-edge clock
//                rst   - asynchronous active-high reset
//                clr_i - synchronous clear
//                ld_i  - load enable (d_i captured when high)
//                d_i   - stage input
//                q_o   - stage output
//  Revision    : 1.0 - initial release
// ============================================================================
module dff_delay_bank_stage
   import dff_delay_bank_pkg::*;
#(
   parameter int               WIDTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             ld_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= RST_VAL;
      end else if (clr_i) begin
         data_q <= RST_VAL;
      end else if (ld_i) begin
         data_q <= d_i;
      end
   end

   assign q_o = data_q;

endmodule : dff_delay_bank_stage
`default_nettype wire

// File: rtl/dff_delay_bank.sv
`default_nettype none
// ============================================================================
//  Module      : dff_delay_bank
//  Description : Bank of WIDTH independent channels, each a DEPTH-stage
//                register chain with enable, synchronous clear, toggle mode,
//                fill tracking and per-channel edge detection.
//  Ports       : clk   - rising-edge clock
//                reset - asynchronous active-high reset
//                en    - advance enable
//                clr   - synchronous clear (priority over en)
//                mode  - 00 shift, 01 toggle, 10/11 hold
//                d     - per-channel data in
//                q/qb  - last stage and its complement
//                rise  - q bit went 0->1 at the previous edge
//                fall  - q bit went 1->0 at the previous edge
//                valid - DEPTH advance cycles seen since reset/clear
//  Revision    : 1.0 - initial release
// ============================================================================
module dff_delay_bank
   import dff_delay_bank_pkg::*;
#(
   parameter int               WIDTH   = 4,
   parameter int               DEPTH   = 3,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             valid
);

   localparam int FILL_W = clog2(DEPTH + 1);

   logic [WIDTH-1:0]  stage_q [DEPTH];
   logic [WIDTH-1:0]  stage0_d;
   logic              advance;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [WIDTH-1:0]  q_prev_q, q_prev_d;

   // Only shift and toggle modes move data; clear overrides everything.
   always_comb begin
      advance  = 1'b0;
      stage0_d = d;
      case (mode)
         MODE_D:    advance = en & ~clr;
         MODE_T: begin
            advance  = en & ~clr;
            stage0_d = stage_q[0] ^ d;
         end
         MODE_HOLD: advance = 1'b0;
         default:   advance = 1'b0;
      endcase
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            dff_delay_bank_stage #(
               .WIDTH   (WIDTH),
               .RST_VAL (RST_VAL)
            ) u_stage (
               .clk   (clk),
               .rst   (reset),
               .clr_i (clr),
               .ld_i  (advance),
               .d_i   (stage0_d),
               .q_o   (stage_q[gi])
            );
         end else begin : g_chain
            dff_delay_bank_stage #(
               .WIDTH   (WIDTH),
               .RST_VAL (RST_VAL)
            ) u_stage (
               .clk   (clk),
               .rst   (reset),
               .clr_i (clr),
               .ld_i  (advance),
               .d_i   (stage_q[gi-1]),
               .q_o   (stage_q[gi])
            );
         end
      end
   endgenerate

   // Fill counter saturates at DEPTH so valid stays high once filled.
   always_comb begin
      fill_d = fill_q;
      if (clr) begin
         fill_d = '0;
      end else if (advance && (fill_q != FILL_W'(DEPTH))) begin
         fill_d = fill_q + FILL_W'(1);
      end
   end

   // q_prev follows q every edge; clearing it alongside the stages keeps a
   // clear from looking like a data transition on rise/fall.
   always_comb begin
      q_prev_d = q;
      if (clr) begin
         q_prev_d = RST_VAL;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fill_q   <= '0;
         q_prev_q <= RST_VAL;
      end else begin
         fill_q   <= fill_d;
         q_prev_q <= q_prev_d;
      end
   end

   assign q     = stage_q[DEPTH-1];
   assign qb    = ~q;
   assign rise  = q & ~q_prev_q;
   assign fall  = ~q & q_prev_q;
   assign valid = (fill_q == FILL_W'(DEPTH));

endmodule : dff_delay_bank
`default_nettype wire

// File: tb/tb_dff_delay_bank.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
//  Module      : tb_dff_delay_bank
//  Description : Scoreboard bench for dff_delay_bank. A directed driver pushes
//                hand-computed expectations; independent monitors pop and
//                compare. A second WIDTH=1/DEPTH=1 instance is checked as a
//                plain DFF against an asynchronously toggling input.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dff_delay_bank;

   typedef struct {
      logic [3:0] q;
      logic [3:0] rise;
      logic [3:0] fall;
      logic       valid;
      string      tag;
   } exp_t;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       en    = 1'b0;
   logic       clr   = 1'b0;
   logic [1:0] mode  = 2'b00;
   logic [3:0] d     = 4'h0;
   logic [3:0] q, qb, rise, fall;
   logic       valid;

   logic       rst1 = 1'b1;
   logic [0:0] d1   = 1'b0;
   logic [0:0] q1, qb1, rise1, fall1;
   logic       valid1;

   int tests_run    = 0;
   int tests_failed = 0;
   int dff_checks   = 0;

   exp_t       sb  [$];
   logic [0:0] sb1 [$];

   always #5 clk = ~clk;

   dff_delay_bank #(
      .WIDTH   (4),
      .DEPTH   (3),
      .RST_VAL (4'h0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .clr   (clr),
      .mode  (mode),
      .d     (d),
      .q     (q),
      .qb    (qb),
      .rise  (rise),
      .fall  (fall),
      .valid (valid)
   );

   dff_delay_bank #(
      .WIDTH   (1),
      .DEPTH   (1),
      .RST_VAL (1'b0)
   ) dut1 (
      .clk   (clk),
      .reset (rst1),
      .en    (1'b1),
      .clr   (1'b0),
      .mode  (2'b00),
      .d     (d1),
      .q     (q1),
      .qb    (qb1),
      .rise  (rise1),
      .fall  (fall1),
      .valid (valid1)
   );

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply one vector at the falling edge; its expectation describes the
   // outputs just after the following rising edge.
   task automatic step(input logic rst_v, input logic en_v, input logic clr_v,
                       input logic [1:0] mode_v, input logic [3:0] d_v,
                       input logic [3:0] eq, input logic [3:0] er,
                       input logic [3:0] ef, input logic ev, input string tag);
      exp_t e;
      @(negedge clk);
      reset = rst_v;
      en    = en_v;
      clr   = clr_v;
      mode  = mode_v;
      d     = d_v;
      e.q = eq; e.rise = er; e.fall = ef; e.valid = ev; e.tag = tag;
      sb.push_back(e);
   endtask

   // Main monitor: wakes on every clock edge and on asynchronous reset.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk or posedge reset);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, ".q"},     q,            e.q);
            check({e.tag, ".qb"},    qb,           ~e.q);
            check({e.tag, ".rise"},  rise,         e.rise);
            check({e.tag, ".fall"},  fall,         e.fall);
            check({e.tag, ".valid"}, {3'b0, valid}, {3'b0, e.valid});
         end
      end
   end

   // Plain-DFF instance: input toggles off the clock grid every 3 ns.
   initial begin
      #0.5;
      forever #3 d1 = ~d1;
   end

   initial begin
      #12 rst1 = 1'b0;
   end

   always @(posedge clk) begin
      if (!rst1 && dff_checks < 20) begin
         sb1.push_back(d1);
         dff_checks++;
      end
   end

   initial begin
      logic [0:0] e1;
      forever begin
         @(posedge clk);
         #1;
         if (sb1.size() > 0) begin
            e1 = sb1.pop_front();
            check("dff1.q",  {3'b0, q1},  {3'b0, e1});
            check("dff1.qb", {3'b0, qb1}, {3'b0, ~e1});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      // Reset held for ten edges.
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0, 1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, "reset");
      end
      // Single pulse through three stages.
      step(1'b0, 1'b1, 1'b0, 2'b00, 4'hA, 4'h0, 4'h0, 4'h0, 1'b0, "pulse1");
      step(1'b0, 1'b1, 1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, "pulse2");
      step(1'b0, 1'b1, 1'b0, 2'b00, 4'h0, 4'hA, 4'hA, 4'h0, 1'b1, "pulse3");
      step(1'b0, 1'b1, 1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 4'hA, 1'b1, "pulse4");
      step(1'b0, 1'b1, 1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, "pulse5");
      // Two stall cycles while 5 is in transit.
      step(1'b0, 1'b1, 1'b0, 2'b00, 4'h5, 4'h0, 4'h0, 4'h0, 1'b1, "stall1");
      step(1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, "stall2");
      step(1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, "stall3");
      step(1'b0, 1'b1, 1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, "stall4");
      step(1'b0, 1'b1, 1'b0, 2'b00, 4'h0, 4'h5, 4'h5, 4'h0, 1'b1, "stall5");
      step(1'b0, 1'b1, 1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 4'h5, 1'b1, "stall6");
      // Hold and reserved modes ignore d.
      step(1'b0, 1'b1, 1'b0, 2'b10, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1, "hold10");
      step(1'b0, 1'b1, 1'b0, 2'b11, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1, "hold11");
      // Toggle mode, d=1 for four advances then 0.
      step(1'b0, 1'b1, 1'b0, 2'b01, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1, "tog1");
      step(1'b0, 1'b1, 1'b0, 2'b01, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1, "tog2");
      step(1'b0, 1'b1, 1'b0, 2'b01, 4'h1, 4'h1, 4'h1, 4'h0, 1'b1, "tog3");
      step(1'b0, 1'b1, 1'b0, 2'b01, 4'h1, 4'h0, 4'h0, 4'h1, 1'b1, "tog4");
      step(1'b0, 1'b1, 1'b0, 2'b01, 4'h0, 4'h1, 4'h1, 4'h0, 1'b1, "tog5");
      step(1'b0, 1'b1, 1'b0, 2'b01, 4'h0, 4'h0, 4'h0, 4'h1, 1'b1, "tog6");
      step(1'b0, 1'b1, 1'b0, 2'b01, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, "tog7");
      // Fill with F, then clear alongside enable.
      step(1'b0, 1'b1, 1'b0, 2'b00, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1, "fillF1");
      step(1'b0, 1'b1, 1'b0, 2'b00, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1, "fillF2");
      step(1'b0, 1'b1, 1'b0, 2'b00, 4'hF, 4'hF, 4'hF, 4'h0, 1'b1, "fillF3");
      step(1'b0, 1'b1, 1'b0, 2'b00, 4'hF, 4'hF, 4'h0, 4'h0, 1'b1, "fillF4");
      step(1'b0, 1'b1, 1'b1, 2'b00, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, "clr");
      // Refill with a stall: valid needs three real advances.
      step(1'b0, 1'b1, 1'b0, 2'b00, 4'h3, 4'h0, 4'h0, 4'h0, 1'b0, "refill1");
      step(1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, "refill2");
      step(1'b0, 1'b1, 1'b0, 2'b00, 4'h3, 4'h0, 4'h0, 4'h0, 1'b0, "refill3");
      step(1'b0, 1'b1, 1'b0, 2'b00, 4'h3, 4'h3, 4'h3, 4'h0, 1'b1, "refill4");
      step(1'b0, 1'b1, 1'b0, 2'b00, 4'h3, 4'h3, 4'h0, 4'h0, 1'b1, "refill5");
      // Asynchronous reset between edges while q=3.
      @(negedge clk);
      #2;
      e.q = 4'h0; e.rise = 4'h0; e.fall = 4'h0; e.valid = 1'b0; e.tag = "async";
      sb.push_back(e);
      reset = 1'b1;
      step(1'b1, 1'b1, 1'b0, 2'b00, 4'h3, 4'h0, 4'h0, 4'h0, 1'b0, "inreset");
      // First edge after release advances.
      step(1'b0, 1'b1, 1'b0, 2'b00, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, "post1");
      step(1'b0, 1'b1, 1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, "post2");
      step(1'b0, 1'b1, 1'b0, 2'b00, 4'h0, 4'h1, 4'h1, 4'h0, 1'b1, "post3");
      repeat (3) @(negedge clk);
      check("sb_drained",  4'(sb.size()),  4'h0);
      check("sb1_drained", 4'(sb1.size()), 4'h0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_dff_delay_bank
`default_nettype wire
